// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared state encoding and width helper for the round-robin adder scheduler
package adder_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/hadder8bit.sv
// hadder8bit: shared combinational 8-bit adder, sum modulo 256
module hadder8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; search starts one past the last-granted index
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    logic w_found;

    // first requester after the pointer wins, wrapping modulo NREQ
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IDW-1:0] j;
            j = IDW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[j]) begin
                w_found    = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = j;
            end
        end
    end

endmodule

// File: rtl/adder8_rr_sched.sv
// adder8_rr_sched: round-robin scheduler for one shared adder; ADDER_SCHED_OVF_EN enables carry-out flag
module adder8_rr_sched
    import adder_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [NREQ*W-1:0] i_req_a,
    input  logic [NREQ*W-1:0] i_req_b,
    output logic [NREQ-1:0] o_req_ready,
    output logic [W-1:0]    o_add_a,
    output logic [W-1:0]    o_add_b,
    input  logic [W-1:0]    i_add_o,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [IDW-1:0]  o_rsp_id,
    output logic [W-1:0]    o_rsp_o,
    output logic            o_rsp_ovf
);

    state_t          r_state, w_next;
    logic [IDW-1:0]  r_ptr, r_id, r_rsp_id, w_idx;
    logic [W-1:0]    r_a, r_b, r_sum;
    logic            r_valid;
    logic [NREQ-1:0] w_grant;
    logic            w_acc;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_acc       = (r_state == S_IDLE) && |w_grant;
    assign o_req_ready = (r_state == S_IDLE && i_rst_n) ? w_grant : '0;
    assign o_add_a     = r_a;
    assign o_add_b     = r_b;
    assign o_rsp_valid = r_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_o     = r_sum;

    // next state: accept in IDLE, one cycle of CALC, hold RESP until consumed
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_acc ? S_CALC : S_IDLE;
            S_CALC:  w_next = S_RESP;
            S_RESP:  w_next = i_rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // operand capture, result capture and response retirement
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr    <= IDW'(NREQ - 1);
            r_id     <= '0;
            r_rsp_id <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_a   <= i_req_a[w_idx*W +: W];
                r_b   <= i_req_b[w_idx*W +: W];
                r_id  <= w_idx;
                r_ptr <= w_idx;
            end
            if (r_state == S_CALC) begin
                r_sum    <= i_add_o;
                r_rsp_id <= r_id;
                r_valid  <= 1'b1;
            end
            if (r_state == S_RESP && i_rsp_ready) r_valid <= 1'b0;
        end
    end

`ifdef ADDER_SCHED_OVF_EN
    logic r_ovf;

    // a wrapped unsigned sum is smaller than either operand
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_ovf <= 1'b0;
        else if (r_state == S_CALC)  r_ovf <= i_add_o < r_a;
    end

    assign o_rsp_ovf = r_ovf;
`else
    assign o_rsp_ovf = 1'b0;
`endif

endmodule
